// File: rtl/opna_wrq_pkg.sv
// Shared types and constants for the OPNA register-write queue: FSM states,
// FIFO entry layout {a1, isdata, byte} and default bus idle times.
package opna_wrq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_WAIT
  } state_e;

  localparam int ENTRY_W       = 10;
  localparam int BYTE_LSB      = 0;
  localparam int BYTE_W        = 8;
  localparam int ISDATA_BIT    = 8;
  localparam int A1_BIT        = 9;

  localparam int ADDR_WAIT_DEF = 17;
  localparam int DATA_WAIT_DEF = 83;

endpackage

// File: rtl/opna_wrq_if.sv
// Host-side write port of the OPNA write queue: write strobe with its
// address/data fields, overflow clear, and the full/overflow status back.
interface opna_wrq_if;
  logic       h_wr;
  logic       h_a1;
  logic       h_isdata;
  logic [7:0] h_din;
  logic       h_clr_ovf;
  logic       h_full;
  logic       h_ovf;

  modport master (
    output h_wr, h_a1, h_isdata, h_din, h_clr_ovf,
    input  h_full, h_ovf
  );

  modport slave (
    input  h_wr, h_a1, h_isdata, h_din, h_clr_ovf,
    output h_full, h_ovf
  );
endinterface

// File: rtl/opna_wrq_fifo.sv
// Synchronous DEPTH x ENTRY_W FIFO with a first-word-fall-through head.
// A push on a full FIFO is accepted only when a pop frees the slot in the same clk.
module opna_wrq_fifo
  import opna_wrq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ENTRY_W-1:0]       din_i,
  output logic [ENTRY_W-1:0]       head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is data only; occupancy is governed by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/opna_wrq.sv
// OPNA register-write queue: buffers host writes and replays them to jt08 with
// cen-paced strobes and post-write idle time. OPNA_WRQ_ADDR_DEDUP_EN skips repeated address writes.
module opna_wrq
  import opna_wrq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_WAIT = ADDR_WAIT_DEF,
  parameter int DATA_WAIT = DATA_WAIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  opna_wrq_if.slave              hif,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   cs_n,
  output logic                   wr_n,
  output logic [1:0]             addr,
  output logic [7:0]             dout
);
  localparam int WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stb_q, stb_d;
  logic               cs_n_q, cs_n_d;
  logic               wr_n_q, wr_n_d;
  logic [1:0]         addr_q, addr_d;
  logic [7:0]         dout_q, dout_d;
  logic               ovf_q, ovf_d;
  logic               pop, drop, dup;
  logic [ENTRY_W-1:0] head;
  logic               empty, full;

  opna_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (hif.h_wr),
    .pop_i   (pop),
    .din_i   ({hif.h_a1, hif.h_isdata, hif.h_din}),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .level_o (level)
  );

`ifdef OPNA_WRQ_ADDR_DEDUP_EN
  logic [8:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  assign dup = !head[ISDATA_BIT] && last_vld_q &&
               ({head[A1_BIT], head[BYTE_LSB +: BYTE_W]} == last_q);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    pop     = 1'b0;
`ifdef OPNA_WRQ_ADDR_DEDUP_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
`endif
    if (cen) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            pop = 1'b1;
            // A duplicate address is consumed here without leaving IDLE.
            if (!dup) begin
              state_d = ST_SETUP;
              cs_n_d  = 1'b0;
              addr_d  = {head[A1_BIT], head[ISDATA_BIT]};
              dout_d  = head[BYTE_LSB +: BYTE_W];
`ifdef OPNA_WRQ_ADDR_DEDUP_EN
              if (!head[ISDATA_BIT]) begin
                last_d     = {head[A1_BIT], head[BYTE_LSB +: BYTE_W]};
                last_vld_d = 1'b1;
              end
`endif
            end
          end
        end
        ST_SETUP: begin
          state_d = ST_STROBE;
          wr_n_d  = 1'b0;
          stb_d   = 1'b0;
        end
        ST_STROBE: begin
          if (stb_q) begin
            state_d = ST_HOLD;
            wr_n_d  = 1'b1;
          end else begin
            stb_d = 1'b1;
          end
        end
        ST_HOLD: begin
          state_d = ST_WAIT;
          cs_n_d  = 1'b1;
          cnt_d   = addr_q[0] ? CNT_W'(DATA_WAIT - 1) : CNT_W'(ADDR_WAIT - 1);
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A simultaneous drop beats the host's clear request.
  assign drop  = hif.h_wr && full && !pop;
  assign ovf_d = drop ? 1'b1 : (hif.h_clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef OPNA_WRQ_ADDR_DEDUP_EN
      last_q     <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
`ifdef OPNA_WRQ_ADDR_DEDUP_EN
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
`endif
    end
  end

  assign cs_n       = cs_n_q;
  assign wr_n       = wr_n_q;
  assign addr       = addr_q;
  assign dout       = dout_q;
  assign busy       = !empty || (state_q != ST_IDLE);
  assign hif.h_full = full;
  assign hif.h_ovf  = ovf_q;

endmodule

// File: doc/opna_wrq.md
OPNA_WRQ -- requirements
Module: opna_wrq

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter ADDR_WAIT, default 17: cen ticks of idle bus after an address write.
REQ-003 Parameter DATA_WAIT, default 83: cen ticks of idle bus after a data write.
REQ-004 Port rst  in  1  synchronous active-high reset.
REQ-005 Port clk  in  1  single clock; all logic on its rising edge.
REQ-006 Port cen  in  1  clock enable for bus timing, the same cen that drives jt08.
REQ-007 Port h_wr  in  1  host write strobe, one clk wide, not gated by cen.
REQ-008 Port h_a1  in  1  register bank select: 0 = ports 0/1, 1 = ports 2/3.
REQ-009 Port h_isdata  in  1  0 = address write, 1 = data write.
REQ-010 Port h_din  in  8  host write byte.
REQ-011 Port h_clr_ovf  in  1  clears h_ovf.
REQ-012 Port h_full  out  1  FIFO full.
REQ-013 Port h_ovf  out  1  sticky flag: a write was dropped.
REQ-014 Port level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 Port busy  out  1  FIFO not empty or FSM not IDLE.
REQ-016 Port cs_n, wr_n  out  1 each  chip strobes to jt08.
REQ-017 Port addr  out  2  {a1, isdata} to jt08.
REQ-018 Port dout  out  8  data byte to jt08 din.

Function
REQ-019 FIFO entry SHALL be 10 bits, {a1, isdata, byte}.
REQ-020 A push SHALL be accepted when h_wr=1 and (not full, or a pop occurs in the same clk).
REQ-021 h_wr on a full FIFO with no pop SHALL drop the write and set h_ovf=1.
REQ-022 h_ovf SHALL stay set until h_clr_ovf or rst; if h_clr_ovf and a drop occur in the same clk, the set wins.
REQ-023 FSM states: IDLE, SETUP, STROBE, HOLD, WAIT. The FSM SHALL advance only on clk edges with cen=1.
REQ-024 IDLE: when the FIFO is non-empty, pop the head, latch addr/dout, go to SETUP with cs_n=0 and wr_n=1.
REQ-025 SETUP: one tick, then go to STROBE with wr_n=0.
REQ-026 STROBE: exactly 2 ticks with wr_n=0, then go to HOLD with wr_n=1 and cs_n still 0.
REQ-027 HOLD: one tick, then go to WAIT with cs_n=1. Load the wait counter with ADDR_WAIT-1 or DATA_WAIT-1, selected by the entry's isdata.
REQ-028 WAIT: decrement each tick; at 0 go to IDLE.
REQ-029 addr and dout SHALL stay stable from SETUP entry through HOLD exit, and hold their last value otherwise.
REQ-030 A pushed entry SHALL become visible to IDLE on the clk after the push; no combinational path from push to pop.
REQ-031 With cen held at 0, bus outputs SHALL not change; pushes still proceed.
REQ-032 level SHALL be exact every clk, including simultaneous push and pop.

Reset
REQ-033 On rst: state=IDLE, cs_n=1, wr_n=1, addr=0, dout=0, FIFO empty, level=0, h_full=0, h_ovf=0, busy=0.
REQ-034 rst asserted mid-transaction SHALL abandon the transaction; strobes return high on the next clk regardless of cen.

Configuration
REQ-035 Macro OPNA_WRQ_ADDR_DEDUP_EN defined: in IDLE, an address entry whose {a1, byte} equals the last address issued on the bus SHALL be popped and discarded with no bus cycle. The FSM stays in IDLE, at a cost of one cen tick. The last-address register is invalidated by rst.
REQ-036 Macro undefined: every entry SHALL produce a bus cycle, and the last-address register SHALL not be synthesized.

Structure
REQ-037 Package opna_wrq_pkg SHALL hold: the state enum, the entry width constant (10), the field offsets, and the ADDR_WAIT/DATA_WAIT defaults.
REQ-038 Storage SHALL be a sub-module opna_wrq_fifo (DEPTH×10, synchronous, first-word-fall-through head); the FSM and counters live in opna_wrq.

Verification
REQ-039 Address then data path: after rst, push addr 0x28 (a1=0), then data 0xF0, cen=1.
- Expected: addr=00, dout=28, then addr=01, dout=F0; wr_n low 2 ticks each.
- Expected: wr_n high for 20 ticks between the two strobes; busy drops 84 ticks after the 2nd wr_n rise.
REQ-040 Full/overflow: hold cen=0 and push 9 entries.
- Expected: level=8, h_full=1, h_ovf=1, bus outputs unchanged.
- Then pulse h_clr_ovf: expected h_ovf=0.
REQ-041 Bank select: push a1=1 data 0x55.
- Expected: addr=11 during the strobe.
REQ-042 Reset mid-transaction: assert rst during STROBE.
- Expected on the next clk: cs_n=1, wr_n=1, level=0, busy=0.
- Then push addr 0x10: expected a normal cycle.
REQ-043 Simultaneous push/pop: FIFO full, with the FSM popping in IDLE.
- Expected: the write is accepted, level stays 8, h_ovf=0.
REQ-044 Address dedup: push addr 0x10 (a1=1) twice.
- With OPNA_WRQ_ADDR_DEDUP_EN: expected one bus address cycle.
- Without the macro: expected two bus address cycles.
